// File: rtl/stack_engine.sv
// Hardware stack controller: PUSH/POP/CALL/RET over a single-port word memory
// with a downward-growing stack pointer and overflow/underflow detection.
module stack_engine #(
  parameter logic [31:0] STACK_TOP   = 32'd900,
  parameter logic [31:0] STACK_LIMIT = 32'd800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] push_data,
  input  logic [31:0] pc_in,
  input  logic        sp_load,
  input  logic [31:0] sp_load_val,
  output logic        op_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] sp_out,
  output logic [31:0] pop_data,
  output logic [31:0] pc_out,
  output logic        done,
  output logic        ovf,
  output logic        udf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [31:0] sp_r, addr_r, wdata_r, pop_data_r, pc_out_r;
  logic        req_r, we_r, done_r, ovf_r, udf_r, is_ret_r;
  logic        start_write_s, start_read_s, ovf_s, udf_s, ack_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and transaction-start decode; op_code bit0 selects read, bit1 selects CALL/RET
  always_comb begin
    next_state_s  = state_r;
    start_write_s = 1'b0;
    start_read_s  = 1'b0;
    ovf_s         = 1'b0;
    udf_s         = 1'b0;
    ack_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (sp_load) begin
          next_state_s = IDLE;
        end else if (op_valid) begin
          if (!op_code[0]) begin
            if (sp_r == STACK_LIMIT) begin
              ovf_s = 1'b1;
            end else begin
              start_write_s = 1'b1;
              next_state_s  = WRITE;
            end
          end else begin
            if (sp_r == STACK_TOP) begin
              udf_s = 1'b1;
            end else begin
              start_read_s = 1'b1;
              next_state_s = READ;
            end
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WRITE, READ: begin
        if (mem_ack) begin
          ack_s        = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Datapath: stack pointer, memory request registers, results and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_r       <= STACK_TOP;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      pop_data_r <= 32'd0;
      pc_out_r   <= 32'd0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
      is_ret_r   <= 1'b0;
    end else begin
      done_r <= ack_s;
      ovf_r  <= ovf_s;
      udf_r  <= udf_s;
      if ((state_r == IDLE) && sp_load) begin
        sp_r <= sp_load_val;
      end else if (start_write_s) begin
        req_r   <= 1'b1;
        we_r    <= 1'b1;
        addr_r  <= sp_r;
        wdata_r <= op_code[1] ? pc_in : push_data;
      end else if (start_read_s) begin
        req_r    <= 1'b1;
        we_r     <= 1'b0;
        addr_r   <= sp_r + 32'd1;
        is_ret_r <= op_code[1];
      end else if (ack_s) begin
        req_r <= 1'b0;
        we_r  <= 1'b0;
        if (state_r == WRITE) begin
          sp_r <= sp_r - 32'd1;
        end else begin
          sp_r <= sp_r + 32'd1;
          if (is_ret_r) begin
            pc_out_r <= mem_rdata;
          end else begin
            pop_data_r <= mem_rdata;
          end
        end
      end
    end
  end

  assign op_ready  = (state_r == IDLE);
  assign mem_req   = req_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign sp_out    = sp_r;
  assign pop_data  = pop_data_r;
  assign pc_out    = pc_out_r;
  assign done      = done_r;
  assign ovf       = ovf_r;
  assign udf       = udf_r;

endmodule
